// File: rtl/fifo_rd_stream_pkg.sv
// Shared definitions for the FIFO read-side stream adapter.
//   - default parameter values for data width, prefetch depth and counter width
//   - controller state encoding
//   - helper to size occupancy counters for a given buffer depth
package fifo_rd_stream_pkg;

    localparam int DEF_WIDTH     = 8;
    localparam int DEF_BUF_DEPTH = 4;
    localparam int DEF_CNT_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FLUSH = 2'd3
    } state_e;

    // Occupancy must represent 0..depth inclusive.
    function automatic int occ_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_rd_stream_if.sv
// Bus bundle between the FIFO read port, the read-stream adapter and the
// downstream consumer.
//   FIFO side : fifo_rd_en (strobe), fifo_rdata (valid the cycle after the
//               strobe), fifo_empty, fifo_underflow
//   Stream    : out_valid, out_data, out_ready
// Stream handshake: a word transfers on every rd_clk edge where out_valid and
// out_ready are both high. Once out_valid is high, out_data and out_valid hold
// until the transfer happens; out_valid never depends on out_ready.
// master = the adapter, slave = the FIFO/consumer environment.
interface fifo_rd_stream_if
    import fifo_rd_stream_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             fifo_rd_en;
    logic             fifo_empty;
    logic             fifo_underflow;
    logic [WIDTH-1:0] fifo_rdata;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;

    modport master (
        output fifo_rd_en,
        input  fifo_empty,
        input  fifo_underflow,
        input  fifo_rdata,
        output out_valid,
        output out_data,
        input  out_ready
    );

    modport slave (
        input  fifo_rd_en,
        output fifo_empty,
        output fifo_underflow,
        output fifo_rdata,
        input  out_valid,
        input  out_data,
        output out_ready
    );
endinterface

// File: rtl/fifo_rd_stream_buf.sv
// Small circular buffer with push, pop, occupancy and synchronous clear.
//   clk, rst_n  : clock, asynchronous active-low reset
//   clear       : empties the buffer and rewinds both pointers (wins over push/pop)
//   push/push_data : write one word at the tail (ignored when full)
//   pop         : drop the head word (ignored when empty)
//   head_data   : current head entry
//   occupancy   : number of stored words, 0..DEPTH
//   not_empty   : occupancy != 0
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module fifo_rd_stream_buf
    import fifo_rd_stream_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_BUF_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int OCC_W = occ_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [OCC_W-1:0] occupancy,
    output logic             not_empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             push_ok;
    logic             pop_ok;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        push_ok  = push && (occ_q != OCC_W'(DEPTH));
        pop_ok   = pop && (occ_q != '0);
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            // Push and pop together leave the count unchanged.
            if (push_ok && !pop_ok) begin
                occ_d = occ_q + OCC_W'(1);
            end else if (pop_ok && !push_ok) begin
                occ_d = occ_q - OCC_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    assign head_data = mem_q[rd_ptr_q];
    assign occupancy = occ_q;
    assign not_empty = (occ_q != '0);

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side consumer for an asynchronous FIFO (rd_clk domain). Prefetches
// FIFO words into a local circular buffer and presents them on a valid/ready
// stream at up to one word per cycle.
//   rd_clk, rst_n  : clock, asynchronous active-low reset
//   enable         : level, permits fetching
//   flush          : one-cycle pulse, discards buffered data and empties the FIFO
//   bus            : FIFO read port + downstream stream (master modport)
//   busy           : controller not idle
//   word_cnt       : words accepted downstream, wraps
//   err            : sticky; FIFO underflow or a read issued against an empty FIFO
//   dbg_state      : controller state
//   dbg_occupancy  : local buffer occupancy
module fifo_rd_stream
    import fifo_rd_stream_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int BUF_DEPTH = DEF_BUF_DEPTH,
    parameter int CNT_WIDTH = DEF_CNT_WIDTH,
    localparam int OCC_W    = occ_width(BUF_DEPTH)
) (
    input  logic                 rd_clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 flush,
    fifo_rd_stream_if.master     bus,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] word_cnt,
    output logic                 err,
    output state_e               dbg_state,
    output logic [OCC_W-1:0]     dbg_occupancy
);

    state_e               state_q, state_d;
    logic                 inflight_q, inflight_d;
    logic [CNT_WIDTH-1:0] word_cnt_q, word_cnt_d;
    logic                 err_q, err_d;

    logic                 rd_en;
    logic                 buf_clear;
    logic                 buf_push;
    logic                 buf_pop;
    logic [WIDTH-1:0]     buf_head;
    logic [OCC_W-1:0]     occ;
    logic                 buf_not_empty;
    logic [OCC_W:0]       committed;
    logic                 room;

    // Words already stored plus the one returning from last cycle's read.
    // Only registered state feeds this, so out_ready never reaches rd_en.
    assign committed = {1'b0, occ} + {{OCC_W{1'b0}}, inflight_q};
    assign room      = committed < (OCC_W + 1)'(BUF_DEPTH);

    always_comb begin
        state_d   = state_q;
        rd_en     = 1'b0;
        buf_clear = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // A flush with nothing in the FIFO has nothing to do.
                if (flush && !bus.fifo_empty) begin
                    state_d   = ST_FLUSH;
                    buf_clear = 1'b1;
                end else if (enable) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                rd_en = !bus.fifo_empty && room;
                if (flush) begin
                    state_d   = ST_FLUSH;
                    buf_clear = 1'b1;
                end else if (!enable) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (flush) begin
                    state_d   = ST_FLUSH;
                    buf_clear = 1'b1;
                end else if (enable) begin
                    state_d = ST_RUN;
                end else if (occ == '0 && !inflight_q) begin
                    state_d = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                // Read data is thrown away here, so no buffer limit applies.
                rd_en = !bus.fifo_empty;
                if (bus.fifo_empty && !inflight_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        inflight_d = rd_en;
        // Data returning during FLUSH is dropped; clear also overrides a push
        // on the cycle the flush is taken.
        buf_push   = inflight_q && (state_q != ST_FLUSH);
        buf_pop    = buf_not_empty && bus.out_ready;
        word_cnt_d = word_cnt_q + CNT_WIDTH'(buf_pop);
        err_d      = err_q || bus.fifo_underflow || (rd_en && bus.fifo_empty);
    end

    always_ff @(posedge rd_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            inflight_q <= 1'b0;
            word_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            inflight_q <= inflight_d;
            word_cnt_q <= word_cnt_d;
            err_q      <= err_d;
        end
    end

    fifo_rd_stream_buf #(
        .WIDTH (WIDTH),
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk       (rd_clk),
        .rst_n     (rst_n),
        .clear     (buf_clear),
        .push      (buf_push),
        .push_data (bus.fifo_rdata),
        .pop       (buf_pop),
        .head_data (buf_head),
        .occupancy (occ),
        .not_empty (buf_not_empty)
    );

    assign bus.fifo_rd_en = rd_en;
    assign bus.out_valid  = buf_not_empty;
    assign bus.out_data   = buf_head;
    assign busy           = (state_q != ST_IDLE);
    assign word_cnt       = word_cnt_q;
    assign err            = err_q;
    assign dbg_state      = state_q;
    assign dbg_occupancy  = occ;

endmodule

// File: tb/tb_fifo_rd_stream.sv
module tb_fifo_rd_stream;
    import fifo_rd_stream_pkg::*;

    localparam int W   = 8;
    localparam int CW  = 16;
    localparam int OW  = 3;

    logic           rd_clk = 1'b0;
    logic           rst_n;
    logic           enable;
    logic           flush;
    logic           busy;
    logic [CW-1:0]  word_cnt;
    logic           err;
    state_e         dbg_state;
    logic [OW-1:0]  dbg_occupancy;

    fifo_rd_stream_if #(.WIDTH(W)) bus ();

    fifo_rd_stream #(
        .WIDTH     (W),
        .BUF_DEPTH (4),
        .CNT_WIDTH (CW)
    ) dut (
        .rd_clk        (rd_clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .flush         (flush),
        .bus           (bus),
        .busy          (busy),
        .word_cnt      (word_cnt),
        .err           (err),
        .dbg_state     (dbg_state),
        .dbg_occupancy (dbg_occupancy)
    );

    // ---------------- clock ----------------
    always #5 rd_clk = ~rd_clk;

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int rd_count = 0;
    int first_rd_cyc, first_valid_cyc, first_pop_cyc, last_pop_cyc;

    logic [W-1:0] fifo_q [$];   // FIFO contents model
    logic [W-1:0] exp_q  [$];   // words expected downstream, in order

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic push_word(input logic [W-1:0] d);
        fifo_q.push_back(d);
        exp_q.push_back(d);
        bus.fifo_empty = 1'b0;
    endtask

    // Word placed in the FIFO that must never reach the stream.
    task automatic push_raw(input logic [W-1:0] d);
        fifo_q.push_back(d);
        bus.fifo_empty = 1'b0;
    endtask

    // One clock: sample at negedge (scoreboard), then model the FIFO read
    // port just after the rising edge. Returns at posedge+1.
    task automatic tick();
        logic         rd;
        logic [W-1:0] e;
        @(negedge rd_clk);
        rd = bus.fifo_rd_en;
        if (rd) begin
            rd_count++;
            if (first_rd_cyc < 0) first_rd_cyc = cyc;
        end
        if (bus.out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (bus.out_valid && bus.out_ready) begin
            if (first_pop_cyc < 0) first_pop_cyc = cyc;
            last_pop_cyc = cyc;
            if (exp_q.size() == 0) begin
                check("unexpected_pop", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("pop_data", 32'(bus.out_data), 32'(e));
            end
        end
        @(posedge rd_clk);
        cyc++;
        #1;
        if (rd && rst_n && fifo_q.size() > 0) bus.fifo_rdata = fifo_q.pop_front();
        bus.fifo_empty = (fifo_q.size() == 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int guard;
        int n;
        logic ok;

        rst_n              = 1'b0;
        enable             = 1'b0;
        flush              = 1'b0;
        bus.fifo_empty     = 1'b1;
        bus.fifo_underflow = 1'b0;
        bus.fifo_rdata     = '0;
        bus.out_ready      = 1'b0;
        first_rd_cyc = -1; first_valid_cyc = -1; first_pop_cyc = -1; last_pop_cyc = -1;
        #2;
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        check("rst_rd_en", 32'(bus.fifo_rd_en), 32'd0);
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        repeat (3) tick();
        rst_n = 1'b1;

        // ---- latency / throughput: 0x11,0x22,0x33 ----
        push_word(8'h11); push_word(8'h22); push_word(8'h33);
        enable        = 1'b1;
        bus.out_ready = 1'b1;
        guard = 0;
        while (exp_q.size() != 0 && guard < 30) begin tick(); guard++; end
        check("lat_timeout", 32'(exp_q.size()), 32'd0);
        check("lat_first", 32'(first_valid_cyc - first_rd_cyc), 32'd2);
        check("lat_pop_first", 32'(first_pop_cyc), 32'(first_valid_cyc));
        check("lat_back2back", 32'(last_pop_cyc - first_pop_cyc), 32'd2);
        check("lat_word_cnt", 32'(word_cnt), 32'd3);

        // ---- backpressure: 10 words, consumer stalled ----
        bus.out_ready = 1'b0;
        rd_count = 0;
        for (int i = 0; i < 10; i++) push_word(8'hA0 + 8'(i));
        repeat (10) tick();
        check("bp_reads", 32'(rd_count), 32'd4);
        check("bp_occ", 32'(dbg_occupancy), 32'd4);
        check("bp_rd_en_low", 32'(bus.fifo_rd_en), 32'd0);
        check("bp_valid", 32'(bus.out_valid), 32'd1);
        bus.out_ready = 1'b1;
        guard = 0;
        while (exp_q.size() != 0 && guard < 40) begin tick(); guard++; end
        check("bp_timeout", 32'(exp_q.size()), 32'd0);
        check("bp_word_cnt", 32'(word_cnt), 32'd13);
        check("bp_fifo_empty", 32'(fifo_q.size()), 32'd0);

        // ---- drain with 3 buffered ----
        bus.out_ready = 1'b0;
        rd_count = 0;
        push_word(8'h51); push_word(8'h52); push_word(8'h53);
        guard = 0;
        while (dbg_occupancy != 3'd3 && guard < 10) begin tick(); guard++; end
        check("dr_fill_timeout", 32'(dbg_occupancy), 32'd3);
        enable = 1'b0;
        tick();
        check("dr_state", 32'(dbg_state), 32'(ST_DRAIN));
        push_raw(8'hE1); push_raw(8'hE2);
        repeat (3) tick();
        check("dr_busy", 32'(busy), 32'd1);
        bus.out_ready = 1'b1;
        guard = 0;
        while (dbg_state != ST_IDLE && guard < 10) begin tick(); guard++; end
        check("dr_idle", 32'(dbg_state), 32'(ST_IDLE));
        check("dr_reads", 32'(rd_count), 32'd3);
        check("dr_busy_low", 32'(busy), 32'd0);
        check("dr_word_cnt", 32'(word_cnt), 32'd16);
        check("dr_exp_left", 32'(exp_q.size()), 32'd0);

        // ---- flush: 2 buffered, 1 inflight, 5 in FIFO ----
        bus.out_ready = 1'b0;
        for (int i = 0; i < 6; i++) push_raw(8'hC0 + 8'(i));
        enable = 1'b1;
        guard = 0;
        while (dbg_occupancy != 3'd2 && guard < 10) begin tick(); guard++; end
        check("fl_occ2", 32'(dbg_occupancy), 32'd2);
        check("fl_fifo5", 32'(fifo_q.size()), 32'd5);
        flush  = 1'b1;
        enable = 1'b0;
        tick();
        flush = 1'b0;
        check("fl_valid_low", 32'(bus.out_valid), 32'd0);
        check("fl_state", 32'(dbg_state), 32'(ST_FLUSH));
        check("fl_occ0", 32'(dbg_occupancy), 32'd0);
        guard = 0;
        while (dbg_state != ST_IDLE && guard < 20) begin tick(); guard++; end
        check("fl_idle", 32'(dbg_state), 32'(ST_IDLE));
        check("fl_fifo_drained", 32'(fifo_q.size()), 32'd0);
        check("fl_word_cnt", 32'(word_cnt), 32'd16);
        check("fl_valid_idle", 32'(bus.out_valid), 32'd0);
        // flush in IDLE with an empty FIFO is ignored
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fl_ignored", 32'(dbg_state), 32'(ST_IDLE));

        // ---- sticky error ----
        check("err_clear", 32'(err), 32'd0);
        bus.fifo_underflow = 1'b1;
        tick();
        bus.fifo_underflow = 1'b0;
        check("err_set", 32'(err), 32'd1);
        repeat (5) tick();
        check("err_sticky", 32'(err), 32'd1);

        // ---- mid-stream asynchronous reset ----
        enable = 1'b1;
        push_word(8'h71); push_word(8'h72); push_word(8'h73);
        repeat (4) tick();
        check("mr_pre_valid", 32'(bus.out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mr_valid", 32'(bus.out_valid), 32'd0);
        check("mr_data", 32'(bus.out_data), 32'd0);
        check("mr_rd_en", 32'(bus.fifo_rd_en), 32'd0);
        check("mr_busy", 32'(busy), 32'd0);
        check("mr_word_cnt", 32'(word_cnt), 32'd0);
        check("mr_err", 32'(err), 32'd0);
        check("mr_state", 32'(dbg_state), 32'(ST_IDLE));
        check("mr_occ", 32'(dbg_occupancy), 32'd0);
        fifo_q.delete();
        exp_q.delete();
        bus.fifo_empty = 1'b1;
        enable = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;

        // ---- word counter wrap ----
        enable        = 1'b1;
        bus.out_ready = 1'b1;
        n = 0;
        guard = 0;
        while ((n < 65535 || exp_q.size() != 0) && guard < 70000) begin
            if (n < 65535 && fifo_q.size() < 4) begin
                push_word(8'(n));
                n++;
            end
            tick();
            guard++;
        end
        ok = (exp_q.size() == 0) && (n == 65535);
        check("wrap_fill_done", 32'(ok), 32'd1);
        check("wrap_max", 32'(word_cnt), 32'hFFFF);
        push_word(8'h5A);
        guard = 0;
        while (exp_q.size() != 0 && guard < 20) begin tick(); guard++; end
        check("wrap_last_done", 32'(exp_q.size()), 32'd0);
        check("wrap_zero", 32'(word_cnt), 32'd0);
        check("wrap_err_clear", 32'(err), 32'd0);

        // ---- report ----
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fifo_rd_stream.md
Name: fifo_rd_stream

Overview:
Read-side consumer for the asynchronous FIFO. It lives in the rd_clk domain and drives the FIFO read port (rd_en, rdata, empty, underflow). It prefetches words into a small local buffer and presents them downstream on a valid/ready stream, with full throughput and no combinational path from out_ready to fifo_rd_en. It adds enable/drain/flush control, a word counter and a sticky error flag.

Parameters:
WIDTH, 8, data width; matches the FIFO data width.
BUF_DEPTH, 4, local prefetch buffer entries; power of 2 and at least 3 for 1 word/cycle.
CNT_WIDTH, 16, width of the delivered-word counter.

Ports:
rd_clk  input  1  FIFO read clock; the only clock.
rst_n  input  1  asynchronous reset, active-low.
enable  input  1  level; permits fetching.
flush  input  1  single-cycle pulse; discards the buffer and empties the FIFO.
fifo_empty  input  1  FIFO empty flag.
fifo_underflow  input  1  FIFO underflow flag.
fifo_rdata  input  WIDTH  FIFO read data; valid the cycle after fifo_rd_en.
fifo_rd_en  output  1  FIFO read strobe.
out_valid  output  1  downstream data valid.
out_data  output  WIDTH  downstream data.
out_ready  input  1  downstream accept.
busy  output  1  high when state is not IDLE.
word_cnt  output  CNT_WIDTH  count of words accepted downstream; wraps.
err  output  1  sticky; set by fifo_underflow=1 or by a read issued while fifo_empty=1.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; buffer occupancy=0; inflight=0; fifo_rd_en=0; out_valid=0; out_data=0; busy=0; word_cnt=0; err=0.
- States:
  - IDLE -> RUN when enable=1.
  - RUN -> DRAIN when enable=0.
  - DRAIN -> RUN when enable=1.
  - DRAIN -> IDLE when occupancy=0 and inflight=0.
  - RUN or DRAIN -> FLUSH on flush=1.
  - FLUSH -> IDLE when fifo_empty=1 and inflight=0.
  - flush in IDLE: go to FLUSH only if fifo_empty=0; otherwise ignored.
- Issue rule, RUN only: fifo_rd_en = !fifo_empty and (occupancy + inflight < BUF_DEPTH). Computed from registered state plus fifo_empty; never depends on out_ready.
- FLUSH issue rule: fifo_rd_en = !fifo_empty. No occupancy limit.
- DRAIN issues no reads.
- inflight is a 1-bit register equal to last cycle's fifo_rd_en. When inflight=1, fifo_rdata is written into the buffer tail, except in FLUSH where it is discarded.
- Buffer: circular, BUF_DEPTH entries, read/write pointers plus an occupancy counter.
  - out_valid = occupancy != 0; out_data = head entry.
  - A pop occurs when out_valid and out_ready.
  - Simultaneous push and pop leaves occupancy unchanged.
  - Pointers wrap modulo BUF_DEPTH.
- Latency: a FIFO word present while RUN with an empty buffer appears on out_valid 2 cycles after fifo_rd_en is asserted.
- Throughput: with BUF_DEPTH>=3, a non-empty FIFO and out_ready=1, one word per cycle in steady state.
- On entering FLUSH: occupancy=0, pointers=0, out_valid=0 on the next cycle.
- word_cnt increments by 1 per pop and wraps from 2^CNT_WIDTH-1 to 0.
- err is cleared only by reset.
- Data order is strictly preserved.
- A mid-operation reset discards the buffer and inflight data.

Decomposition:
- Shared package holds the state enum: IDLE=2'd0, RUN=2'd1, DRAIN=2'd2, FLUSH=2'd3.
- Shared package holds the defaults WIDTH=8, BUF_DEPTH=4, CNT_WIDTH=16.
- One sub-module: fifo_rd_stream_buf. It is the circular buffer with push, pop, occupancy and clear, and it is reusable by other stream adapters.

Test Plan:
- Reset values: assert rst_n=0 mid-stream -> all outputs 0 immediately, state IDLE, occupancy=0.
- Latency: enable=1, out_ready=1, FIFO holds 0x11,0x22,0x33 -> out_data 0x11,0x22,0x33 on consecutive cycles; first word appears 2 cycles after first fifo_rd_en; word_cnt=3.
- Backpressure: 10 words in FIFO, out_ready=0 -> exactly 4 reads issued and fifo_rd_en stays 0; out_ready=1 -> 10 words delivered in order, no loss or duplicate.
- Drain: enable dropped with 3 words buffered -> no further fifo_rd_en; state DRAIN until 3 pops, then IDLE and busy=0.
- Flush: flush pulse with 2 buffered, 1 inflight and 5 words in FIFO -> out_valid=0 the next cycle; reads continue until fifo_empty; nothing delivered; state IDLE; word_cnt unchanged.
- Error and wrap: pulse fifo_underflow -> err=1 and stays 1. Preload word_cnt path with 65535 pops, then one more -> word_cnt=0.
